// File: rtl/mp_add_sequencer_pkg.sv
// Shared encodings for the multi-precision add/subtract sequencer.
// FSM state values and the word width of the shared adder.
package mp_add_sequencer_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/Adder_32bits.sv
// 32-bit ripple adder with carry-in/carry-out; the single shared arithmetic
// resource that the sequencer time-multiplexes across operand words.
module Adder_32bits
    import mp_add_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] iA,
    input  logic [WORD_W-1:0] iB,
    input  logic              iC,
    output logic [WORD_W-1:0] S,
    output logic              oC
);

    logic [WORD_W:0] sum_w;

    assign sum_w = {1'b0, iA} + {1'b0, iB} + {{WORD_W{1'b0}}, iC};
    assign S     = sum_w[WORD_W-1:0];
    assign oC    = sum_w[WORD_W];

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract: streams W-bit operands LSW first through one
// 32-bit adder, chaining the carry through a register between words.
module mp_add_sequencer
    import mp_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    op_sub,
    input  logic [WORD_W*WORDS-1:0] op_a,
    input  logic [WORD_W*WORDS-1:0] op_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W*WORDS-1:0] result,
    output logic                    carry_out,
    output logic                    overflow,
    output logic                    busy
);

    localparam int W     = WORD_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t               state_q, state_d;
    logic [W-1:0]         a_q, b_q, result_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 carry_q, carry_out_q, overflow_q;
    logic                 last_w;
    logic [WORD_W-1:0]    a_w, b_w, sum_w;
    logic                 co_w;

    // Two's-complement overflow: same-sign operands yielding a different-sign sum.
    function automatic logic signed_ovf(input logic signed [WORD_W-1:0] a,
                                        input logic signed [WORD_W-1:0] b,
                                        input logic signed [WORD_W-1:0] s);
        return (a[WORD_W-1] == b[WORD_W-1]) && (s[WORD_W-1] != a[WORD_W-1]);
    endfunction

    assign last_w = (idx_q == IDX_W'(WORDS - 1));
    assign a_w    = a_q[idx_q*WORD_W +: WORD_W];
    assign b_w    = b_q[idx_q*WORD_W +: WORD_W];

    Adder_32bits u_adder (
        .iA (a_w),
        .iB (b_w),
        .iC (carry_q),
        .S  (sum_w),
        .oC (co_w)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_w)    state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    // Subtraction is A + ~B + 1: invert B once here, seed carry with 1.
                    if (in_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_b ^ {W{op_sub}};
                        carry_q <= op_sub;
                        idx_q   <= '0;
                    end
                end
                ST_RUN: begin
                    result_q[idx_q*WORD_W +: WORD_W] <= sum_w;
                    carry_q <= co_w;
                    if (last_w) begin
                        carry_out_q <= co_w;
                        overflow_q  <= signed_ovf(a_w, b_w, sum_w);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Scoreboard bench for mp_add_sequencer (WORDS=4): directed corner cases,
// backpressure, mid-run reset and randomised traffic against a W-bit model.
module tb_mp_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    logic         clk, rst_n, in_valid, in_ready, op_sub, out_valid, out_ready;
    logic         carry_out, overflow, busy;
    logic [W-1:0] op_a, op_b, result;

    exp_t sb[$];
    exp_t cur;
    bit   seen;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   ready_mode = 0;

    mp_add_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic fail_now(input string nm);
        total_cnt++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    // out_ready policy: 0 = always ready, 1 = random, 2 = held low
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: pop on the first DONE cycle of each result, then check it stays held.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    cur = sb.pop_front();
                    chk("result", result, cur.r);
                    chk("carry_out", W'(carry_out), W'(cur.c));
                    chk("overflow", W'(overflow), W'(cur.v));
                    chk("latency", W'(cyc), W'(cur.acc + WORDS));
                end
                seen = 1'b1;
            end else begin
                chk("held_result", result, cur.r);
            end
            if (out_ready) seen = 1'b0;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] er, input logic ec, input logic ev);
        exp_t e;
        bit   done = 1'b0;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (in_ready && rst_n) begin
                e.r = er; e.c = ec; e.v = ev; e.acc = cyc + 1;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        op_sub   = 1'b0;
        if (!done) fail_now("accept_timeout");
    endtask

    task automatic rand_op(input int gap);
        logic [W-1:0] a, b, beff, r;
        logic         s, c, v;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 7))
            0: a = '1;
            1: b = a;
            2: a = {1'b0, {(W-1){1'b1}}};
            3: b = '0;
            default: ;
        endcase
        s    = 1'($urandom_range(0, 1));
        beff = s ? ~b : b;
        {c, r} = {1'b0, a} + {1'b0, beff} + (W+1)'(s);
        v = (a[W-1] == beff[W-1]) && (r[W-1] != a[W-1]);
        repeat (gap) begin @(posedge clk); #1; end
        do_op(a, b, s, r, c, v);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) fail_now("drain_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        bit got_valid;
        rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; op_a = '0; op_b = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_result", result, '0);
        chk("rst_flags", W'({carry_out, overflow}), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases
        do_op('1, W'(1), 1'b0, '0, 1'b1, 1'b0);
        do_op({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
        do_op('0, W'(1), 1'b1, '1, 1'b0, 1'b0);
        do_op(W'(5), W'(5), 1'b1, '0, 1'b1, 1'b0);
        wait_drain();

        // Backpressure: a second request waits behind a stalled result
        ready_mode = 2;
        @(posedge clk); #1;
        do_op(W'(3), W'(4), 1'b0, W'(7), 1'b0, 1'b0);
        fork
            do_op(W'(10), W'(3), 1'b1, W'(7), 1'b1, 1'b0);
            begin
                got_valid = 1'b0;
                for (int k = 0; k < 20 && !got_valid; k++) begin
                    @(negedge clk);
                    got_valid = out_valid;
                end
                if (!got_valid) fail_now("bp_valid_timeout");
                repeat (6) begin
                    @(negedge clk);
                    chk("bp_in_ready", W'(in_ready), W'(0));
                    chk("bp_out_valid", W'(out_valid), W'(1));
                end
                ready_mode = 0;
            end
        join
        wait_drain();

        // Reset in the middle of RUN (idx==2)
        do_op(W'(123), W'(456), 1'b0, W'(579), 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        chk("mid_rst_out_valid", W'(out_valid), W'(0));
        chk("mid_rst_busy", W'(busy), W'(0));
        chk("mid_rst_result", result, '0);
        chk("mid_rst_flags", W'({carry_out, overflow}), W'(0));
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(W'(32'hFFFF_FFFF), W'(1), 1'b0, {{(W-33){1'b0}}, 33'h1_0000_0000}, 1'b0, 1'b0);
        wait_drain();

        // Randomised traffic with gaps and random consumer stalls
        ready_mode = 1;
        for (int n = 0; n < 2000; n++) rand_op($urandom_range(0, 3));
        ready_mode = 0;
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
